// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_arbiter
// Purpose  : Round-robin arbiter sharing one i2c_master_top between two clients.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_addr_2byte,
  input  logic        c0_read_req,
  input  logic        c0_write_req,
  output logic        c0_read_req_ack,
  output logic        c0_write_req_ack,
  input  logic [7:0]  c0_dev_addr,
  input  logic [15:0] c0_reg_addr,
  input  logic [7:0]  c0_write_data,
  output logic [7:0]  c0_read_data,
  output logic        c0_error,
  input  logic        c1_addr_2byte,
  input  logic        c1_read_req,
  input  logic        c1_write_req,
  output logic        c1_read_req_ack,
  output logic        c1_write_req_ack,
  input  logic [7:0]  c1_dev_addr,
  input  logic [15:0] c1_reg_addr,
  input  logic [7:0]  c1_write_data,
  output logic [7:0]  c1_read_data,
  output logic        c1_error,
  output logic        m_addr_2byte,
  output logic        m_read_req,
  output logic        m_write_req,
  output logic [7:0]  m_dev_addr,
  output logic [15:0] m_reg_addr,
  output logic [7:0]  m_write_data,
  input  logic        m_read_req_ack,
  input  logic        m_write_req_ack,
  input  logic [7:0]  m_read_data,
  input  logic        m_error,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic        r_last_c1,  w_last_c1_nxt;
  logic [1:0]  r_grant,    w_grant_nxt;
  logic        r_op_write, w_op_write_nxt;

  logic        r_m_a2,  w_m_a2_nxt;
  logic        r_m_rd,  w_m_rd_nxt;
  logic        r_m_wr,  w_m_wr_nxt;
  logic [7:0]  r_m_dev, w_m_dev_nxt;
  logic [15:0] r_m_reg, w_m_reg_nxt;
  logic [7:0]  r_m_wd,  w_m_wd_nxt;

  logic [7:0]  r_c0_rd,   w_c0_rd_nxt;
  logic        r_c0_err,  w_c0_err_nxt;
  logic        r_c0_rack, w_c0_rack_nxt;
  logic        r_c0_wack, w_c0_wack_nxt;
  logic [7:0]  r_c1_rd,   w_c1_rd_nxt;
  logic        r_c1_err,  w_c1_err_nxt;
  logic        r_c1_rack, w_c1_rack_nxt;
  logic        r_c1_wack, w_c1_wack_nxt;

  logic w_req0, w_req1, w_pick1, w_sel_write, w_m_ack;

  assign w_req0      = c0_read_req | c0_write_req;
  assign w_req1      = c1_read_req | c1_write_req;
  // On a tie the client that did not own the master last time wins.
  assign w_pick1     = w_req1 & (~w_req0 | ~r_last_c1);
  assign w_sel_write = w_pick1 ? c1_write_req : c0_write_req;
  assign w_m_ack     = m_read_req_ack | m_write_req_ack;

  always_comb begin
    w_state_nxt    = r_state;
    w_last_c1_nxt  = r_last_c1;
    w_grant_nxt    = r_grant;
    w_op_write_nxt = r_op_write;
    w_m_a2_nxt     = r_m_a2;
    w_m_rd_nxt     = r_m_rd;
    w_m_wr_nxt     = r_m_wr;
    w_m_dev_nxt    = r_m_dev;
    w_m_reg_nxt    = r_m_reg;
    w_m_wd_nxt     = r_m_wd;
    w_c0_rd_nxt    = r_c0_rd;
    w_c0_err_nxt   = r_c0_err;
    w_c1_rd_nxt    = r_c1_rd;
    w_c1_err_nxt   = r_c1_err;
    w_c0_rack_nxt  = 1'b0;
    w_c0_wack_nxt  = 1'b0;
    w_c1_rack_nxt  = 1'b0;
    w_c1_wack_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          w_state_nxt    = ST_BUSY;
          w_last_c1_nxt  = w_pick1;
          w_grant_nxt    = w_pick1 ? 2'b10 : 2'b01;
          w_op_write_nxt = w_sel_write;
          w_m_wr_nxt     = w_sel_write;
          w_m_rd_nxt     = ~w_sel_write;
          w_m_a2_nxt     = w_pick1 ? c1_addr_2byte : c0_addr_2byte;
          w_m_dev_nxt    = w_pick1 ? c1_dev_addr   : c0_dev_addr;
          w_m_reg_nxt    = w_pick1 ? c1_reg_addr   : c0_reg_addr;
          w_m_wd_nxt     = w_pick1 ? c1_write_data : c0_write_data;
        end
      end
      ST_BUSY: begin
        // Either ack type completes; the client is told the latched op type.
        if (w_m_ack) begin
          w_state_nxt = ST_RELEASE;
          w_m_rd_nxt  = 1'b0;
          w_m_wr_nxt  = 1'b0;
          if (r_grant[1]) begin
            w_c1_err_nxt  = m_error;
            w_c1_wack_nxt = r_op_write;
            w_c1_rack_nxt = ~r_op_write;
            if (!r_op_write) w_c1_rd_nxt = m_read_data;
          end else begin
            w_c0_err_nxt  = m_error;
            w_c0_wack_nxt = r_op_write;
            w_c0_rack_nxt = ~r_op_write;
            if (!r_op_write) w_c0_rd_nxt = m_read_data;
          end
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
        w_m_rd_nxt  = 1'b0;
        w_m_wr_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_c1  <= 1'b1;
      r_grant    <= 2'b00;
      r_op_write <= 1'b0;
      r_m_a2     <= 1'b0;
      r_m_rd     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_dev    <= 8'h00;
      r_m_reg    <= 16'h0000;
      r_m_wd     <= 8'h00;
      r_c0_rd    <= 8'h00;
      r_c0_err   <= 1'b0;
      r_c0_rack  <= 1'b0;
      r_c0_wack  <= 1'b0;
      r_c1_rd    <= 8'h00;
      r_c1_err   <= 1'b0;
      r_c1_rack  <= 1'b0;
      r_c1_wack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_c1  <= w_last_c1_nxt;
      r_grant    <= w_grant_nxt;
      r_op_write <= w_op_write_nxt;
      r_m_a2     <= w_m_a2_nxt;
      r_m_rd     <= w_m_rd_nxt;
      r_m_wr     <= w_m_wr_nxt;
      r_m_dev    <= w_m_dev_nxt;
      r_m_reg    <= w_m_reg_nxt;
      r_m_wd     <= w_m_wd_nxt;
      r_c0_rd    <= w_c0_rd_nxt;
      r_c0_err   <= w_c0_err_nxt;
      r_c0_rack  <= w_c0_rack_nxt;
      r_c0_wack  <= w_c0_wack_nxt;
      r_c1_rd    <= w_c1_rd_nxt;
      r_c1_err   <= w_c1_err_nxt;
      r_c1_rack  <= w_c1_rack_nxt;
      r_c1_wack  <= w_c1_wack_nxt;
    end
  end

  assign m_addr_2byte     = r_m_a2;
  assign m_read_req       = r_m_rd;
  assign m_write_req      = r_m_wr;
  assign m_dev_addr       = r_m_dev;
  assign m_reg_addr       = r_m_reg;
  assign m_write_data     = r_m_wd;
  assign c0_read_data     = r_c0_rd;
  assign c0_error         = r_c0_err;
  assign c0_read_req_ack  = r_c0_rack;
  assign c0_write_req_ack = r_c0_wack;
  assign c1_read_data     = r_c1_rd;
  assign c1_error         = r_c1_err;
  assign c1_read_req_ack  = r_c1_rack;
  assign c1_write_req_ack = r_c1_wack;
  assign grant            = r_grant;
  assign busy             = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_arbiter
// Purpose  : Directed bench with master model and completion/grant scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

  logic        clk, rst_n;
  logic        c0_addr_2byte, c0_read_req, c0_write_req, c0_read_req_ack, c0_write_req_ack;
  logic [7:0]  c0_dev_addr, c0_write_data, c0_read_data;
  logic [15:0] c0_reg_addr;
  logic        c0_error;
  logic        c1_addr_2byte, c1_read_req, c1_write_req, c1_read_req_ack, c1_write_req_ack;
  logic [7:0]  c1_dev_addr, c1_write_data, c1_read_data;
  logic [15:0] c1_reg_addr;
  logic        c1_error;
  logic        m_addr_2byte, m_read_req, m_write_req;
  logic [7:0]  m_dev_addr, m_write_data, m_read_data;
  logic [15:0] m_reg_addr;
  logic        m_read_req_ack, m_write_req_ack, m_error;
  logic [1:0]  grant;
  logic        busy;

  i2c_master_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c0_addr_2byte(c0_addr_2byte), .c0_read_req(c0_read_req), .c0_write_req(c0_write_req),
    .c0_read_req_ack(c0_read_req_ack), .c0_write_req_ack(c0_write_req_ack),
    .c0_dev_addr(c0_dev_addr), .c0_reg_addr(c0_reg_addr), .c0_write_data(c0_write_data),
    .c0_read_data(c0_read_data), .c0_error(c0_error),
    .c1_addr_2byte(c1_addr_2byte), .c1_read_req(c1_read_req), .c1_write_req(c1_write_req),
    .c1_read_req_ack(c1_read_req_ack), .c1_write_req_ack(c1_write_req_ack),
    .c1_dev_addr(c1_dev_addr), .c1_reg_addr(c1_reg_addr), .c1_write_data(c1_write_data),
    .c1_read_data(c1_read_data), .c1_error(c1_error),
    .m_addr_2byte(m_addr_2byte), .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_write_data(m_write_data),
    .m_read_req_ack(m_read_req_ack), .m_write_req_ack(m_write_req_ack),
    .m_read_data(m_read_data), .m_error(m_error),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cl;
    logic       wr;
    logic [7:0] rd;
    logic       err;
  } cexp_t;

  typedef struct {
    logic [1:0]  gr;
    logic        wr;
    logic        a2;
    logic [7:0]  dev;
    logic [15:0] rg;
    logic [7:0]  wd;
  } gexp_t;

  cexp_t exp_q[$];
  gexp_t gq[$];
  logic [7:0] exp_rd [2];

  int         n_total = 0;
  int         n_pass  = 0;
  int         mdl_lat = 10;
  logic       mdl_err = 1'b0;
  logic [7:0] mdl_rdata = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic req(input int cl, input logic wr, input logic a2, input logic [7:0] dev,
                     input logic [15:0] rg, input logic [7:0] wd);
    gexp_t g;
    g.gr = (cl == 1) ? 2'b10 : 2'b01;
    g.wr = wr; g.a2 = a2; g.dev = dev; g.rg = rg; g.wd = wd;
    gq.push_back(g);
    if (cl == 1) begin
      c1_write_req = wr; c1_read_req = ~wr; c1_addr_2byte = a2;
      c1_dev_addr = dev; c1_reg_addr = rg; c1_write_data = wd;
    end else begin
      c0_write_req = wr; c0_read_req = ~wr; c0_addr_2byte = a2;
      c0_dev_addr = dev; c0_reg_addr = rg; c0_write_data = wd;
    end
  endtask

  task automatic drop(input int cl);
    if (cl == 1) begin c1_write_req = 1'b0; c1_read_req = 1'b0; end
    else begin c0_write_req = 1'b0; c0_read_req = 1'b0; end
  endtask

  task automatic expect_done(input int cl, input logic wr, input logic err);
    cexp_t e;
    if (!wr) exp_rd[cl] = mdl_rdata;
    e.cl = cl; e.wr = wr; e.rd = exp_rd[cl]; e.err = err;
    exp_q.push_back(e);
  endtask

  function automatic logic ack_of(input int cl);
    return (cl == 1) ? (c1_read_req_ack | c1_write_req_ack) : (c0_read_req_ack | c0_write_req_ack);
  endfunction

  task automatic wait_ack(input int cl, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_of(cl) && cyc < 2000);
    check($sformatf("ack_seen_c%0d", cl), ack_of(cl), 1);
    drop(cl);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {busy, grant}, 0);
    check({tag, "_master"}, {m_addr_2byte, m_read_req, m_write_req, m_dev_addr, m_reg_addr, m_write_data}, 0);
    check({tag, "_client"}, {c0_read_data, c1_read_data, c0_error, c1_error,
                             c0_read_req_ack, c0_write_req_ack, c1_read_req_ack, c1_write_req_ack}, 0);
  endtask

  // Master model: ack mdl_lat cycles after seeing a request, abort on reset.
  initial begin
    m_read_req_ack = 1'b0; m_write_req_ack = 1'b0; m_error = 1'b0; m_read_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && (m_read_req || m_write_req)) begin
        logic aborted;
        aborted = 1'b0;
        for (int i = 0; i < mdl_lat; i++) begin
          @(negedge clk);
          if (!rst_n) begin aborted = 1'b1; break; end
        end
        if (!aborted) begin
          m_error = mdl_err;
          m_read_data = mdl_rdata;
          if (m_write_req) m_write_req_ack = 1'b1; else m_read_req_ack = 1'b1;
          @(negedge clk);
          m_read_req_ack = 1'b0; m_write_req_ack = 1'b0; m_error = 1'b0; m_read_data = 8'h00;
        end
      end
    end
  end

  // Monitor: grant/field ownership while requesting, completions vs scoreboard.
  initial begin
    gexp_t cur;
    cexp_t e;
    logic  cur_v, prev_req, req_now;
    cur_v = 1'b0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_v = 1'b0; prev_req = 1'b0;
      end else begin
        req_now = m_read_req | m_write_req;
        if (req_now && !prev_req) begin
          if (gq.size() == 0) check("gq_underflow", gq.size(), 1);
          else begin cur = gq.pop_front(); cur_v = 1'b1; end
        end
        if (req_now && cur_v) begin
          check("own_grant", grant, cur.gr);
          check("own_op", {m_write_req, m_read_req}, {cur.wr, ~cur.wr});
          check("own_dev", m_dev_addr, cur.dev);
          check("own_reg", m_reg_addr, cur.rg);
          check("own_wdata", m_write_data, cur.wd);
          check("own_a2", m_addr_2byte, cur.a2);
        end
        prev_req = req_now;
        if (ack_of(0) || ack_of(1)) begin
          if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            check("sb_client", {ack_of(1), ack_of(0)}, (e.cl == 1) ? 2'b10 : 2'b01);
            check("sb_type", (e.cl == 1) ? {c1_write_req_ack, c1_read_req_ack}
                                         : {c0_write_req_ack, c0_read_req_ack}, {e.wr, ~e.wr});
            check("sb_rdata", (e.cl == 1) ? c1_read_data : c0_read_data, e.rd);
            check("sb_error", (e.cl == 1) ? c1_error : c0_error, e.err);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    c0_addr_2byte = 0; c0_read_req = 0; c0_write_req = 0; c0_dev_addr = 0; c0_reg_addr = 0; c0_write_data = 0;
    c1_addr_2byte = 0; c1_read_req = 0; c1_write_req = 0; c1_dev_addr = 0; c1_reg_addr = 0; c1_write_data = 0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single write from c0, 100-cycle master latency
    check("t1_idle_busy", busy, 0);
    mdl_lat = 100; mdl_err = 1'b0;
    req(0, 1'b1, 1'b0, 8'hA0, 16'h0012, 8'h5A);
    expect_done(0, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    check("t1_m_write_req", {m_write_req, m_read_req}, 2'b10);
    check("t1_m_fields", {m_addr_2byte, m_dev_addr, m_reg_addr, m_write_data}, {1'b0, 8'hA0, 16'h0012, 8'h5A});
    check("t1_busy", busy, 1);
    wait_ack(0, cyc);
    check("t1_ack_latency", cyc, 101);
    check("t1_c0_error", c0_error, 0);
    @(negedge clk);
    check("t1_ack_pulse_len", c0_write_req_ack, 0);
    check("t1_idle_after", {busy, grant}, 3'b000);

    // Single read from c1 with a 2-byte register address
    mdl_lat = 10; mdl_rdata = 8'hC3;
    req(1, 1'b0, 1'b1, 8'hA2, 16'h1234, 8'h00);
    expect_done(1, 1'b0, 1'b0);
    wait_ack(1, cyc);
    check("t2_c1_rdata", c1_read_data, 8'hC3);
    check("t2_c0_rdata_kept", c0_read_data, 8'h00);
    @(negedge clk);

    // Simultaneous requests twice: c0, c1, c0, c1
    for (int r = 0; r < 2; r++) begin
      mdl_lat = 8; mdl_rdata = (r == 0) ? 8'h3C : 8'h5E;
      req(0, 1'b0, r[0], 8'hA4 + 8'(4 * r), 16'h0030 + 16'(r), 8'h00);
      req(1, 1'b1, r[0], 8'hA6 + 8'(4 * r), 16'h0040 + 16'(r), 8'h77 + 8'(r));
      expect_done(0, 1'b0, 1'b0);
      expect_done(1, 1'b1, 1'b0);
      wait_ack(0, cyc);
      wait_ack(1, cyc);
      @(negedge clk);
    end
    check("t3_c0_rdata", c0_read_data, 8'h5E);
    check("t3_c1_rdata_kept", c1_read_data, 8'hC3);

    // NACK on c0 write, then cleared by a successful write
    mdl_lat = 5; mdl_err = 1'b1;
    req(0, 1'b1, 1'b0, 8'hA0, 16'h0050, 8'h01);
    expect_done(0, 1'b1, 1'b1);
    wait_ack(0, cyc);
    check("t4_c0_err_set", c0_error, 1);
    check("t4_c1_err_kept", c1_error, 0);
    check("t4_c0_rdata_kept", c0_read_data, 8'h5E);
    @(negedge clk);
    mdl_err = 1'b0;
    req(0, 1'b1, 1'b0, 8'hA0, 16'h0051, 8'h02);
    expect_done(0, 1'b1, 1'b0);
    wait_ack(0, cyc);
    check("t4_c0_err_clr", c0_error, 0);
    @(negedge clk);

    // Field stability while granted
    mdl_lat = 20;
    req(1, 1'b1, 1'b0, 8'hAC, 16'h0060, 8'h11);
    expect_done(1, 1'b1, 1'b0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    c1_write_data = 8'h22;
    @(negedge clk);
    check("t5_wdata_held", m_write_data, 8'h11);
    wait_ack(1, cyc);
    check("t5_wdata_release", m_write_data, 8'h11);
    @(negedge clk);

    // Reset in the middle of a c0 transaction with c1 pending
    mdl_lat = 50; mdl_rdata = 8'h6B;
    req(0, 1'b1, 1'b0, 8'hAE, 16'h0070, 8'h99);
    repeat (6) @(negedge clk);
    check("t6_busy_before", busy, 1);
    req(1, 1'b0, 1'b1, 8'hB0, 16'h0080, 8'h00);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    expect_done(1, 1'b0, 1'b0);
    drop(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_grant_c1", grant, 2'b10);
    check("t6_m_read_req", {m_write_req, m_read_req}, 2'b01);
    wait_ack(1, cyc);
    check("t6_c1_rdata", c1_read_data, 8'h6B);
    check("t6_c0_rdata", c0_read_data, 8'h00);
    @(negedge clk);

    check("sb_drained", exp_q.size(), 0);
    check("gq_drained", gq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Two-client arbiter that shares one `i2c_master_top` between independent requesters, e.g. the EEPROM read/write test logic and a register-configuration sequencer. Each client sees the same request/acknowledge interface that `i2c_master_top` presents. The arbiter grants one client at a time using round-robin priority, latches that client's transaction fields, and forwards them to the master. On completion it routes the master's read data, error flag and acknowledge back to the granted client.

## Interface
No parameters.

- `clk`  in  1  system clock, shared with `i2c_master_top`
- `rst_n`  in  1  asynchronous, active-low reset
- `c0_addr_2byte`, `c1_addr_2byte`  in  1  register address width per client: 1 = 2 bytes, 0 = 1 byte
- `c0_read_req`, `c1_read_req`  in  1  read request, level, held until that client's ack
- `c0_write_req`, `c1_write_req`  in  1  write request, level, held until that client's ack
- `c0_read_req_ack`, `c1_read_req_ack`  out  1  one-cycle read-done pulse
- `c0_write_req_ack`, `c1_write_req_ack`  out  1  one-cycle write-done pulse
- `c0_dev_addr`, `c1_dev_addr`  in  8  device address; bit 0 is ignored
- `c0_reg_addr`, `c1_reg_addr`  in  16  register (word) address
- `c0_write_data`, `c1_write_data`  in  8  write data
- `c0_read_data`, `c1_read_data`  out  8  last read result for that client
- `c0_error`, `c1_error`  out  1  NACK status of that client's last transaction
- `m_addr_2byte`, `m_read_req`, `m_write_req`  out  1  to the master
- `m_dev_addr` (8), `m_reg_addr` (16), `m_write_data` (8)  out  to the master
- `m_read_req_ack`, `m_write_req_ack`  in  1  from the master
- `m_read_data`  in  8  from the master
- `m_error`  in  1  from the master
- `grant`  out  2  one-hot current owner, 00 when idle
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- **Clock and reset:** one clock; reset is asynchronous and active-low.
- **States:** IDLE, BUSY, RELEASE.
- **IDLE:**
  - A client is "requesting" when `cN_read_req | cN_write_req` is high.
  - If only one client is requesting, grant it.
  - If both are requesting, grant the client other than `last_grant`.
  - On grant, register that client's `addr_2byte`, `dev_addr`, `reg_addr` and `write_data` into the `m_*` outputs.
  - Register the operation type: write if `write_req` is high, otherwise read. If a client asserts both, write wins, matching the master.
  - Update `last_grant`, set `grant`, and go to BUSY.
- **BUSY:**
  - Exactly one of `m_write_req` / `m_read_req` is held high, according to the latched operation.
  - All `m_*` fields stay stable, independent of later client input changes.
  - When `m_write_req_ack` or `m_read_req_ack` is sampled high:
    - drop the `m_*_req` outputs;
    - latch `m_error` into the granted client's `cN_error`;
    - on a read, also latch `m_read_data` into `cN_read_data`;
    - pulse the matching `cN_*_req_ack` for one cycle;
    - go to RELEASE.
- **RELEASE:** lasts one cycle, then IDLE with `grant` = 00. It guarantees `m_*_req` is low while the master passes through its own WAIT state.
- **Client rule:** a client must deassert its request at the clock edge following its ack pulse. A request still high in IDLE after that is treated as a new transaction.
- **Result hold:** `cN_read_data` and `cN_error` hold their value until that client's next transaction completes. The other client's completions do not alter them. On a write completion, `cN_read_data` is unchanged.
- **Ignored acks:** an ack from the master outside BUSY is ignored. An ack of the wrong type (read ack for a write) completes the transaction normally and reports the latched operation type to the client.
- **Reset values:**
  - all `cN_*_ack`, `cN_error` and `m_*_req` = 0
  - all `cN_read_data` and `m_*` data/address = 0
  - `grant` = 00, `busy` = 0
  - state = IDLE
  - `last_grant` = client 1, so client 0 wins the first tie
- **Reset mid-transaction:** outputs return to their reset values immediately. The master is expected to be reset by the same source.

## Timing
- **Request to master (1 cycle):** client request sampled high in IDLE at edge n; `m_*_req` and fields valid after edge n. The master sees the request at edge n+1.
- **Master ack to client ack (1 cycle):** master ack high in cycle t is sampled at edge t. The client ack pulse, `cN_read_data` and `cN_error` are all valid in cycle t+1. `cN_read_data` and `cN_error` are valid in the same cycle as the ack and afterwards.
- **Back-to-back:** minimum gap from one client ack to the next `m_*_req` is 2 cycles (RELEASE, then IDLE grant). The master is back in IDLE by then.
- **No preemption:** a grant is never preempted. The other client waits for the full transaction plus 2 cycles.

## Test plan
1. **Single write:** c0 write, dev 0xA0, reg 0x0012, data 0x5A, 1-byte address.
   - Fields appear on `m_*` one cycle later; `grant` = 01.
   - The bench model acks after 100 cycles; `c0_write_req_ack` pulses one cycle later with `c0_error` = 0.
2. **Single read:** c1 read, reg 0x1234, `addr_2byte` = 1; model returns 0xC3.
   - `c1_read_data` = 0xC3, coincident with `c1_read_req_ack`.
   - `c0_read_data` remains 0x00.
3. **Simultaneous requests, twice:** both clients request in the same cycle, twice in a row.
   - Grant order is c0, c1, c0, c1.
   - `m_dev_addr` matches the owner throughout each transaction.
4. **NACK:** model asserts `m_error` = 1 with the ack on c0's write → `c0_error` = 1. c0's next successful write clears it to 0.
5. **Field stability:** c1 changes `c1_write_data` from 0x11 to 0x22 while granted → `m_write_data` stays 0x11 until RELEASE.
6. **Reset mid-transaction:** assert `rst_n` = 0 while in BUSY → all outputs are 0 in the same cycle. After release, a pending c1 request is granted first.
